// File: rtl/node_inject_queue.sv
// Local injection buffer feeding the ring router's two local lanes.
// Each lane is an independent FIFO with a head-of-line starvation monitor.

`ifndef CONTROL_N
`define CONTROL_N 12
`endif

module node_inject_lane #(
    parameter int CTRL_W    = `CONTROL_N,
    parameter int DEPTH     = 4,
    parameter int STARVE_TH = 16,
    parameter int CW        = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] flit,
    input  logic              valid,
    output logic              ready,
    output logic [CTRL_W-1:0] co,
    input  logic              ack,
    output logic [CW-1:0]     count,
    output logic              starve
);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_TH + 1);

    logic [CTRL_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [SW-1:0]     scnt, scnt_nxt;
    logic              enq, deq;

    assign ready = (count != CW'(DEPTH));
    assign enq   = valid & ready;
    assign deq   = ack & (count != '0);
    assign co    = (count != '0) ? {1'b1, mem[rptr][CTRL_W-2:0]} : '0;

    // Counter only runs while a head sits un-acked; any pop or empty lane clears it.
    always_comb begin
        scnt_nxt = scnt;
        if (count == '0 || deq)
            scnt_nxt = '0;
        else if (scnt != SW'(STARVE_TH))
            scnt_nxt = scnt + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (enq)
            mem[wptr] <= flit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            scnt   <= '0;
            starve <= 1'b0;
        end else begin
            if (enq) wptr <= wptr + PW'(1);
            if (deq) rptr <= rptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            scnt   <= scnt_nxt;
            starve <= (scnt_nxt == SW'(STARVE_TH));
        end
    end
endmodule

module node_inject_queue #(
    parameter int CTRL_W    = `CONTROL_N,
    parameter int DEPTH     = 4,
    parameter int STARVE_TH = 16,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] core0_flit,
    input  logic              core0_valid,
    output logic              core0_ready,
    input  logic [CTRL_W-1:0] core1_flit,
    input  logic              core1_valid,
    output logic              core1_ready,
    output logic [CTRL_W-1:0] portl0_co,
    output logic [CTRL_W-1:0] portl1_co,
    input  logic              portl0_ack,
    input  logic              portl1_ack,
    output logic [CW-1:0]     lane0_count,
    output logic [CW-1:0]     lane1_count,
    output logic              starve0,
    output logic              starve1
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0][CTRL_W-1:0] flit, co;
    logic [NUM_LANES-1:0][CW-1:0]     count;
    logic [NUM_LANES-1:0]             valid, ready, ack, starve;

    assign flit  = {core1_flit, core0_flit};
    assign valid = {core1_valid, core0_valid};
    assign ack   = {portl1_ack, portl0_ack};

    assign {core1_ready, core0_ready} = ready;
    assign {portl1_co, portl0_co}     = co;
    assign {lane1_count, lane0_count} = count;
    assign {starve1, starve0}         = starve;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        node_inject_lane #(
            .CTRL_W    (CTRL_W),
            .DEPTH     (DEPTH),
            .STARVE_TH (STARVE_TH),
            .CW        (CW)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .flit   (flit[l]),
            .valid  (valid[l]),
            .ready  (ready[l]),
            .co     (co[l]),
            .ack    (ack[l]),
            .count  (count[l]),
            .starve (starve[l])
        );
    end
endmodule

// File: tb/tb_node_inject_queue.sv
// Directed bench for node_inject_queue (CTRL_W=12, DEPTH=4, STARVE_TH=16).
module tb_node_inject_queue;
    localparam int W = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  core0_flit = '0, core1_flit = '0;
    logic          core0_valid = 1'b0, core1_valid = 1'b0;
    logic          core0_ready, core1_ready;
    logic [W-1:0]  portl0_co, portl1_co;
    logic          portl0_ack = 1'b0, portl1_ack = 1'b0;
    logic [2:0]    lane0_count, lane1_count;
    logic          starve0, starve1;

    int checks = 0;
    int errors = 0;

    node_inject_queue #(.CTRL_W(W), .DEPTH(4), .STARVE_TH(16)) dut (
        .clk(clk), .rst(rst),
        .core0_flit(core0_flit), .core0_valid(core0_valid), .core0_ready(core0_ready),
        .core1_flit(core1_flit), .core1_valid(core1_valid), .core1_ready(core1_ready),
        .portl0_co(portl0_co), .portl1_co(portl1_co),
        .portl0_ack(portl0_ack), .portl1_ack(portl1_ack),
        .lane0_count(lane0_count), .lane1_count(lane1_count),
        .starve0(starve0), .starve1(starve1)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++; if (portl0_co !== 12'h000) begin errors++; $display("FAIL reset_co0 got %h exp 000", portl0_co); end
        checks++; if (portl1_co !== 12'h000) begin errors++; $display("FAIL reset_co1 got %h exp 000", portl1_co); end
        checks++; if (core0_ready !== 1'b1 || core1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b exp 11", core1_ready, core0_ready); end
        checks++; if (lane0_count !== 3'd0 || lane1_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d/%0d exp 0/0", lane0_count, lane1_count); end
        checks++; if (starve0 !== 1'b0 || starve1 !== 1'b0) begin errors++; $display("FAIL reset_starve got %b%b exp 00", starve1, starve0); end
    endtask

    task automatic test_single;
        core0_flit = 12'h0A5; core0_valid = 1'b1;
        tick();
        core0_valid = 1'b0;
        checks++; if (portl0_co !== 12'h8A5) begin errors++; $display("FAIL single_co got %h exp 8a5", portl0_co); end
        checks++; if (lane0_count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", lane0_count); end
        portl0_ack = 1'b1;
        tick();
        portl0_ack = 1'b0;
        checks++; if (lane0_count !== 3'd0) begin errors++; $display("FAIL single_pop_count got %0d exp 0", lane0_count); end
        checks++; if (portl0_co !== 12'h000) begin errors++; $display("FAIL single_pop_co got %h exp 000", portl0_co); end
    endtask

    task automatic test_fill_wrap;
        logic [W-1:0] src [6];
        logic [W-1:0] exp [6];
        src = '{12'h801, 12'h002, 12'h0C3, 12'h7F4, 12'h155, 12'hA66};
        exp = '{12'h801, 12'h802, 12'h8C3, 12'hFF4, 12'h955, 12'hA66};
        core1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            core1_flit = src[i];
            tick();
        end
        checks++; if (core1_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", core1_ready); end
        checks++; if (lane1_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", lane1_count); end
        core1_flit = 12'h3EE;
        tick();
        checks++; if (lane1_count !== 3'd4 || portl1_co !== exp[0]) begin errors++; $display("FAIL fill_drop got cnt %0d co %h exp 4 %h", lane1_count, portl1_co, exp[0]); end
        core1_valid = 1'b0; portl1_ack = 1'b1;
        #1;
        checks++; if (core1_ready !== 1'b0) begin errors++; $display("FAIL full_ack_ready got %b exp 0", core1_ready); end
        tick();
        checks++; if (portl1_co !== exp[1] || core1_ready !== 1'b1) begin errors++; $display("FAIL wrap_pop1 got %h rdy %b exp %h 1", portl1_co, core1_ready, exp[1]); end
        core1_valid = 1'b1;
        for (int i = 4; i < 6; i++) begin
            core1_flit = src[i];
            tick();
            checks++; if (portl1_co !== exp[i-2] || lane1_count !== 3'd3) begin errors++; $display("FAIL wrap_enqdeq%0d got %h cnt %0d exp %h 3", i, portl1_co, lane1_count, exp[i-2]); end
        end
        core1_valid = 1'b0;
        for (int i = 3; i < 6; i++) begin
            checks++; if (portl1_co !== exp[i]) begin errors++; $display("FAIL wrap_order%0d got %h exp %h", i, portl1_co, exp[i]); end
            tick();
        end
        portl1_ack = 1'b0;
        checks++; if (lane1_count !== 3'd0 || portl1_co !== 12'h000) begin errors++; $display("FAIL wrap_empty got cnt %0d co %h exp 0 000", lane1_count, portl1_co); end
    endtask

    task automatic test_simul;
        core0_flit = 12'h111; core0_valid = 1'b1;
        tick();
        checks++; if (portl0_co !== 12'h911 || lane0_count !== 3'd1) begin errors++; $display("FAIL simul_x got %h cnt %0d exp 911 1", portl0_co, lane0_count); end
        core0_flit = 12'h222; portl0_ack = 1'b1;
        tick();
        core0_valid = 1'b0; portl0_ack = 1'b0;
        checks++; if (portl0_co !== 12'hA22 || lane0_count !== 3'd1) begin errors++; $display("FAIL simul_y got %h cnt %0d exp a22 1", portl0_co, lane0_count); end
        portl0_ack = 1'b1;
        tick();
        portl0_ack = 1'b0;
        checks++; if (lane0_count !== 3'd0) begin errors++; $display("FAIL simul_drain got %0d exp 0", lane0_count); end
    endtask

    task automatic test_starve;
        core0_flit = 12'h033; core0_valid = 1'b1;
        tick();
        core0_valid = 1'b0;
        repeat (15) tick();
        checks++; if (starve0 !== 1'b0) begin errors++; $display("FAIL starve_early got %b exp 0", starve0); end
        tick();
        checks++; if (starve0 !== 1'b1) begin errors++; $display("FAIL starve_rise got %b exp 1", starve0); end
        checks++; if (starve1 !== 1'b0 || lane1_count !== 3'd0) begin errors++; $display("FAIL starve_lane1 got %b cnt %0d exp 0 0", starve1, lane1_count); end
        repeat (3) tick();
        checks++; if (starve0 !== 1'b1) begin errors++; $display("FAIL starve_sat got %b exp 1", starve0); end
        portl0_ack = 1'b1;
        tick();
        portl0_ack = 1'b0;
        checks++; if (starve0 !== 1'b0 || lane0_count !== 3'd0) begin errors++; $display("FAIL starve_clear got %b cnt %0d exp 0 0", starve0, lane0_count); end
    endtask

    task automatic test_spurious;
        portl1_ack = 1'b1;
        tick();
        portl1_ack = 1'b0;
        checks++; if (lane1_count !== 3'd0 || portl1_co !== 12'h000) begin errors++; $display("FAIL spur_idle got cnt %0d co %h exp 0 000", lane1_count, portl1_co); end
        core1_flit = 12'h4B7; core1_valid = 1'b1;
        tick();
        core1_valid = 1'b0;
        checks++; if (portl1_co !== 12'hCB7 || lane1_count !== 3'd1) begin errors++; $display("FAIL spur_enq got %h cnt %0d exp cb7 1", portl1_co, lane1_count); end
        portl1_ack = 1'b1;
        tick();
        portl1_ack = 1'b0;
    endtask

    task automatic test_reset_mid;
        core0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            core0_flit = 12'h050 + 12'(i);
            tick();
        end
        core0_valid = 1'b0;
        checks++; if (lane0_count !== 3'd3) begin errors++; $display("FAIL mid_fill got %0d exp 3", lane0_count); end
        #2 rst = 1'b0;
        #1;
        checks++; if (portl0_co !== 12'h000 || lane0_count !== 3'd0) begin errors++; $display("FAIL mid_async got co %h cnt %0d exp 000 0", portl0_co, lane0_count); end
        checks++; if (core0_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", core0_ready); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (lane0_count !== 3'd0 || portl0_co !== 12'h000) begin errors++; $display("FAIL mid_after got cnt %0d co %h exp 0 000", lane0_count, portl0_co); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_wrap();
        test_simul();
        test_starve();
        test_spurious();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
